cpu_mem_responder: RTL and testbench



---
 rtl/cpu_mem_responder.sv | 132 +++++++++++++
 tb/tb_cpu_mem_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the risc_v_cpu imem/dmem ports: instruction/data stores, host loader, MMIO.
// Optional build macro BYTE_STORE_EN adds the dmem_be byte-lane write mask.
module cpu_mem_responder #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          DMEM_DEPTH = 32,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_we,
`ifdef BYTE_STORE_EN
  input  logic [3:0]  dmem_be,
`endif
  output logic [31:0] dmem_rdata,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        running,
  output logic        halt,
  output logic [31:0] tohost,
  output logic [31:0] cycle_count
);

  localparam int          IW  = $clog2(IMEM_DEPTH);
  localparam int          DW  = $clog2(DMEM_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN, S_HALT} state_t;

  state_t        state;
  logic [DW-1:0] clr_idx;
  logic [31:0]   imem [IMEM_DEPTH];
  logic [31:0]   dmem [DMEM_DEPTH];

  logic [3:0] be;
  logic       i_hit;
  logic       d_hit;
  logic       is_tohost;
  logic       is_cycle;
  logic       store;
  logic       load_acc;

`ifdef BYTE_STORE_EN
  assign be = dmem_be;
`else
  assign be = 4'hF;
`endif

  // Full-address compares keep out-of-range accesses from aliasing into the arrays.
  assign i_hit     = imem_addr < 32'(IMEM_DEPTH * 4);
  assign d_hit     = dmem_addr < 32'(DMEM_DEPTH * 4);
  assign is_tohost = dmem_addr == MMIO_BASE;
  assign is_cycle  = dmem_addr == (MMIO_BASE + 32'd4);
  assign store     = dmem_we && (state == S_RUN);
  assign load_acc  = load_valid && load_ready && (load_addr < 32'(IMEM_DEPTH));

  assign imem_data = ((state == S_RUN) && i_hit) ? imem[imem_addr[IW+1:2]] : NOP;

  always_comb begin
    dmem_rdata = '0;
    if (is_tohost)
      dmem_rdata = tohost;
    else if (is_cycle)
      dmem_rdata = cycle_count;
    else if (d_hit)
      dmem_rdata = dmem[dmem_addr[DW+1:2]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_CLEAR;
      clr_idx     <= '0;
      running     <= 1'b0;
      halt        <= 1'b0;
      tohost      <= '0;
      cycle_count <= '0;
      load_ready  <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == DW'(DMEM_DEPTH - 1)) begin
            state      <= S_LOAD;
            load_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_done) begin
            state      <= S_RUN;
            load_ready <= 1'b0;
            running    <= 1'b1;
          end
        end
        S_RUN: begin
          if (cycle_count != '1)
            cycle_count <= cycle_count + 32'd1;
          if (store && is_tohost) begin
            for (int i = 0; i < 4; i++)
              if (be[i]) tohost[8*i +: 8] <= dmem_wdata[8*i +: 8];
            halt    <= 1'b1;
            running <= 1'b0;
            state   <= S_HALT;
          end
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

  // Storage arrays carry no reset; data memory is zeroed by the CLEAR sweep instead.
  always_ff @(posedge clk) begin
    if (load_acc)
      imem[load_addr[IW-1:0]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      dmem[clr_idx] <= '0;
    else if (store && d_hit)
      for (int i = 0; i < 4; i++)
        if (be[i]) dmem[dmem_addr[DW+1:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized self-checking bench for cpu_mem_responder against a phase-level reference model.
module tb_cpu_mem_responder;

  localparam logic [31:0] MMIO = 32'h0000_1000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int P_CLEAR = 0, P_LOAD = 1, P_RUN = 2, P_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic        load_valid, load_ready, load_done, running, halt;
  logic [31:0] load_addr, load_data, tohost, cycle_count;

  cpu_mem_responder dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
`ifdef BYTE_STORE_EN
    .dmem_be(dmem_be),
`endif
    .dmem_rdata(dmem_rdata),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done),
    .running(running), .halt(halt), .tohost(tohost), .cycle_count(cycle_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: phase, remaining clear cycles, store contents, MMIO registers.
  int          phase;
  int          clear_left;
  logic [31:0] m_dmem [32];
  logic [31:0] m_imem [64];
  bit          m_known [64];
  logic [31:0] m_tohost, m_cycles;
  bit          m_halt;

  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  function automatic logic [3:0] eff_be();
`ifdef BYTE_STORE_EN
    return dmem_be;
`else
    return 4'hF;
`endif
  endfunction

  function automatic void model_reset();
    phase      = P_CLEAR;
    clear_left = 32;
    foreach (m_dmem[i]) m_dmem[i] = '0;
    m_tohost = '0;
    m_cycles = '0;
    m_halt   = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [31:0] mk;
    mk = lane_mask(eff_be());
    case (phase)
      P_CLEAR: begin
        clear_left--;
        if (clear_left == 0) phase = P_LOAD;
      end
      P_LOAD: begin
        if (load_valid && load_addr < 64) begin
          m_imem[load_addr]  = load_data;
          m_known[load_addr] = 1'b1;
        end
        if (load_done) phase = P_RUN;
      end
      P_RUN: begin
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        if (dmem_we) begin
          if (dmem_addr == MMIO) begin
            m_tohost = (m_tohost & ~mk) | (dmem_wdata & mk);
            m_halt   = 1'b1;
            phase    = P_HALT;
          end else if (dmem_addr < 128) begin
            m_dmem[dmem_addr / 4] = (m_dmem[dmem_addr / 4] & ~mk) | (dmem_wdata & mk);
          end
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a == MMIO) return m_tohost;
    if (a == MMIO + 4) return m_cycles;
    if (a < 128) return m_dmem[a / 4];
    return 32'h0;
  endfunction

  task automatic check_outputs();
    check_eq("running", {31'b0, running}, {31'b0, phase == P_RUN});
    check_eq("halt", {31'b0, halt}, {31'b0, m_halt});
    check_eq("load_ready", {31'b0, load_ready}, {31'b0, phase == P_LOAD});
    check_eq("tohost", tohost, m_tohost);
    check_eq("cycle_count", cycle_count, m_cycles);
    if (phase != P_CLEAR) check_eq("dmem_rdata", dmem_rdata, exp_rdata(dmem_addr));
    if (phase == P_RUN) begin
      if (imem_addr >= 256) check_eq("imem_oor", imem_data, NOP);
      else if (m_known[imem_addr[7:2]]) check_eq("imem_data", imem_data, m_imem[imem_addr[7:2]]);
    end else begin
      check_eq("imem_idle", imem_data, NOP);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_we    = 1'b1;
    #1;
    check_outputs();
    tick();
    dmem_we = 1'b0;
  endtask

  task automatic probe_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    dmem_addr = a;
    #1;
    check_eq(tag, dmem_rdata, exp);
  endtask

  task automatic run_clear();
    for (int i = 1; i <= 32; i++) begin
      tick();
      check_eq("ready_rise", {31'b0, load_ready}, (i == 32) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic go_run();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  initial begin
    logic [31:0] snap;
    rst = 1'b1;
    imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; dmem_we = 1'b0; dmem_be = 4'hF;
    load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    foreach (m_known[i]) m_known[i] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // CLEAR sweep, then LOAD
    run_clear();
    probe_read("load_rd_0x10", 32'h10, 32'h0);

    load_valid = 1'b1; load_addr = 0; load_data = 32'h0050_0093; tick();
    load_addr = 64; load_data = 32'hDEAD_BEEF; tick();
    for (int i = 0; i < 30; i++) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_addr  = ($urandom_range(0, 7) == 0) ? 32'(64 + $urandom_range(0, 100)) : 32'($urandom_range(1, 63));
      load_data  = $urandom;
      imem_addr  = 32'($urandom_range(0, 127)) << 2;
      #1;
      check_outputs();
      tick();
    end
    // Word offered together with load_done is still written
    load_valid = 1'b1; load_addr = 5; load_data = 32'hA5A5_0005; load_done = 1'b1;
    tick();
    load_valid = 1'b0; load_done = 1'b0;

    imem_addr = 32'h0;   #1; check_eq("imem_word0", imem_data, 32'h0050_0093);
    imem_addr = 32'h100; #1; check_eq("imem_0x100", imem_data, NOP);
    imem_addr = 32'h14;  #1; check_eq("imem_done_word", imem_data, 32'hA5A5_0005);

    store(32'h08, 32'h1234_5678);
    probe_read("raw_0x08", 32'h08, 32'h1234_5678);
    store(32'h80, 32'hCAFE_F00D);
    probe_read("oor_0x80", 32'h80, 32'h0);
    probe_read("no_alias_0x00", 32'h00, exp_rdata(32'h00));
    store(MMIO + 4, 32'h5);

    // Random RUN traffic
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 3);
      imem_addr  = 32'($urandom_range(0, 127)) << 2;
      dmem_wdata = $urandom;
`ifdef BYTE_STORE_EN
      dmem_be = 4'($urandom_range(0, 15));
`endif
      case (op)
        0: begin dmem_addr = 32'($urandom_range(0, 31)) << 2; dmem_we = 1'b1; end
        1: begin dmem_addr = 32'h80 + (32'($urandom_range(0, 900)) << 2); dmem_we = 1'b1; end
        2: begin dmem_addr = ($urandom_range(0, 1) != 0) ? MMIO + 4 : MMIO; dmem_we = 1'b0; end
        default: begin dmem_addr = 32'($urandom_range(0, 63)) << 2; dmem_we = 1'b0; end
      endcase
      #1;
      check_outputs();
      tick();
      dmem_we = 1'b0;
    end
    dmem_be = 4'hF;

`ifdef BYTE_STORE_EN
    store(32'h0C, 32'h1122_3344);
    dmem_be = 4'b0101;
    store(32'h0C, 32'hAABB_CCDD);
    dmem_be = 4'b0000;
    store(32'h0C, 32'hFFFF_FFFF);
    dmem_be = 4'hF;
    probe_read("byte_merge", 32'h0C, 32'h11BB_33DD);
`endif

    // TOHOST halts the run
    store(32'h08, 32'h1234_5678);
    repeat (10) tick();
    store(MMIO, 32'h1);
    check_eq("halt_set", {31'b0, halt}, 32'd1);
    check_eq("tohost_set", tohost, 32'h1);
    snap = m_cycles;
    store(32'h08, 32'hFFFF_0000);
    repeat (4) tick();
    check_eq("cycle_frozen", cycle_count, snap);
    probe_read("halt_store_ignored", 32'h08, 32'h1234_5678);

    // Reset out of HALT, rerun, then async reset mid-RUN
    rst = 1'b1; model_reset(); #1;
    check_eq("rst_halt_clr", {31'b0, halt}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    run_clear();
    go_run();
    store(32'h04, 32'hAA);
    probe_read("run_0x04", 32'h04, 32'hAA);
    repeat (3) tick();
    #2; rst = 1'b1; model_reset(); #1;
    check_eq("async_running", {31'b0, running}, 32'd0);
    check_eq("async_halt", {31'b0, halt}, 32'd0);
    check_eq("async_cycle", cycle_count, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    run_clear();
    probe_read("rezeroed_0x04", 32'h04, 32'h0);
    go_run();
    imem_addr = 32'h0; #1; check_eq("imem_kept", imem_data, 32'h0050_0093);
    for (int i = 0; i < 20; i++) begin
      imem_addr = 32'($urandom_range(0, 127)) << 2;
      dmem_addr = 32'($urandom_range(0, 31)) << 2;
      #1;
      check_outputs();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
